// File: rtl/packet_scheduler_if.sv
// Gate-facing signals of the packet scheduler: start pulse and length towards the gate,
// plus the gate's output handshake, which the scheduler only monitors.
interface packet_scheduler_if #(
    parameter int LEN_WIDTH = 32
);
    logic                 gate_start;
    logic [LEN_WIDTH-1:0] gate_length;
    logic                 mon_tvalid;
    logic                 mon_tready;
    logic                 mon_tlast;

    modport master (
        output gate_start,
        output gate_length,
        input  mon_tvalid,
        input  mon_tready,
        input  mon_tlast
    );

    modport slave (
        input  gate_start,
        input  gate_length,
        output mon_tvalid,
        output mon_tready,
        output mon_tlast
    );
endinterface

// File: rtl/packet_scheduler.sv
// Sequences an AXIS packet gate: start pulse per packet, tlast detection, programmable gap,
// finite or continuous runs, stop request and WAIT-state timeout.
module packet_scheduler #(
    parameter int LEN_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 axis_aclk,
    input  logic                 axis_areset,
    input  logic [LEN_WIDTH-1:0] cfg_length,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic [LEN_WIDTH-1:0] cfg_gap,
    input  logic [LEN_WIDTH-1:0] cfg_timeout,
    input  logic                 ctrl_start,
    input  logic                 ctrl_stop,
    packet_scheduler_if.master   gate,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic                 err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 start_dly_q, start_dly_d;
    logic                 stop_pending_q, stop_pending_d;
    logic [LEN_WIDTH-1:0] length_q, length_d;
    logic [LEN_WIDTH-1:0] gap_sh_q, gap_sh_d;
    logic [LEN_WIDTH-1:0] timeout_sh_q, timeout_sh_d;
    logic [CNT_WIDTH-1:0] cnt_sh_q, cnt_sh_d;
    logic [LEN_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [LEN_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 err_q, err_d;

    logic                 start_edge;
    logic                 transfer;
    logic [CNT_WIDTH-1:0] pkt_next;

    assign start_edge = ctrl_start & ~start_dly_q;
    assign transfer   = gate.mon_tvalid & gate.mon_tready;
    assign pkt_next   = pkt_cnt_q + CNT_WIDTH'(1);

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
        state_d        = state_q;
        start_dly_d    = ctrl_start;
        stop_pending_d = stop_pending_q;
        length_d       = length_q;
        gap_sh_d       = gap_sh_q;
        timeout_sh_d   = timeout_sh_q;
        cnt_sh_d       = cnt_sh_q;
        wait_cnt_d     = wait_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        pkt_cnt_d      = pkt_cnt_q;
        err_d          = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge && cfg_length != '0) begin
                    length_d     = cfg_length;
                    gap_sh_d     = cfg_gap;
                    timeout_sh_d = cfg_timeout;
                    cnt_sh_d     = cfg_count;
                    pkt_cnt_d    = '0;
                    err_d        = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                if (ctrl_stop) stop_pending_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (transfer && gate.mon_tlast) begin
                    pkt_cnt_d  = pkt_next;
                    wait_cnt_d = '0;
                    if (stop_pending_q || ctrl_stop || (cnt_sh_q != '0 && pkt_next == cnt_sh_q)) begin
                        state_d = S_DONE;
                    end else if (gap_sh_q == '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        gap_cnt_d = gap_sh_q;
                        state_d   = S_GAP;
                    end
                end else begin
                    if (ctrl_stop) stop_pending_d = 1'b1;
                    // A gate holding tvalid under backpressure is alive; only silence counts.
                    if (gate.mon_tvalid) begin
                        wait_cnt_d = '0;
                    end else if (timeout_sh_q != '0 && wait_cnt_q == timeout_sh_q - LEN_WIDTH'(1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_GAP: begin
                if (ctrl_stop || stop_pending_q) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q == LEN_WIDTH'(1)) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_WIDTH'(1);
                end
            end
            S_DONE: begin
                stop_pending_d = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (axis_areset) begin
            state_q        <= S_IDLE;
            start_dly_q    <= 1'b0;
            stop_pending_q <= 1'b0;
            length_q       <= '0;
            gap_sh_q       <= '0;
            timeout_sh_q   <= '0;
            cnt_sh_q       <= '0;
            wait_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            pkt_cnt_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_dly_q    <= start_dly_d;
            stop_pending_q <= stop_pending_d;
            length_q       <= length_d;
            gap_sh_q       <= gap_sh_d;
            timeout_sh_q   <= timeout_sh_d;
            cnt_sh_q       <= cnt_sh_d;
            wait_cnt_q     <= wait_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
            err_q          <= err_d;
        end
    end

    assign gate.gate_start  = (state_q == S_ISSUE);
    assign gate.gate_length = length_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign pkt_cnt          = pkt_cnt_q;
    assign err_timeout      = err_q;

endmodule
